if_fetch_stage: RTL
===================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC and issues single-outstanding requests to instruction memory, which has variable latency.
- Buffers one returned instruction and presents it to IF/ID as if_pc_4 / if_instruction.
- Honours the decode stall and redirects from EX (jump/branch), discarding wrong-path fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- cpu_en  in  1  global step enable; low freezes PC/state except response capture.
- id_shouldStall  in  1  IF/ID holding; presented instruction not consumed this cycle.
- ex_shouldJumpOrBranch  in  1  redirect request from EX.
- ex_target  in  32  redirect target PC.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  32  fetch address, word aligned.
- imem_rsp_valid  in  1  response data valid, one cycle pulse.
- imem_rsp_data  in  32  fetched instruction.
- if_valid  out  1  if_instruction/if_pc_4 hold a real instruction.
- if_pc_4  out  32  PC of presented instruction + 4; 0 when !if_valid.
- if_instruction  out  32  presented instruction; 32'h0 (bubble) when !if_valid.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=FETCH, buffer cleared.
  - imem_req_valid=0 while in reset, then 1 from the first cycle after release.
  - if_valid=0, if_pc_4=0, if_instruction=0.
- States: FETCH, WAIT, HOLD, DROP.
- FETCH:
  - imem_req_valid=cpu_en; imem_addr=pc.
  - On handshake (valid&ready), latch req_pc=pc and go to WAIT.
  - The address may change while valid&!ready, but only via redirect.
- WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid: buf_instr=imem_rsp_data, buf_pc=req_pc, go to HOLD.
- HOLD:
  - if_valid=1; if_instruction=buf_instr; if_pc_4=buf_pc+4.
  - Consume when cpu_en & !id_shouldStall: pc<=buf_pc+4, go to FETCH.
  - Fetch throughput is therefore at most one instruction per 3 cycles with zero-wait memory; this is the agreed target.
- DROP:
  - Waiting for the response to a wrong-path request.
  - On imem_rsp_valid, discard the data and go to FETCH.
- Redirect (cpu_en & ex_shouldJumpOrBranch) has the highest priority in every state:
  - pc<=ex_target with bits [1:0] forced to 0.
  - FETCH, no handshake this cycle: stay in FETCH; next request uses the new pc.
  - FETCH, handshake this cycle: the accepted request is wrong-path; go to DROP.
  - WAIT without imem_rsp_valid: go to DROP.
  - WAIT with imem_rsp_valid same cycle: discard the data, go to FETCH.
  - HOLD: discard the buffer (if_valid=0 next cycle), go to FETCH; this applies even if id_shouldStall=1.
  - DROP: stay in DROP (or go to FETCH if the response arrives this cycle); pc updated.
- cpu_en=0:
  - No request is issued, no consume, no redirect, and pc is held.
  - WAIT/DROP still capture or discard imem_rsp_valid, because memory does not retry.
- At most one request is outstanding; imem_rsp_valid is ignored in FETCH/HOLD.
- pc+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
- All outputs except imem_req_valid/imem_addr come from registers (no combinational path from inputs).

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- When defined, adds outputs perf_fetched (32 bits: instructions consumed by IF/ID), perf_stall (32 bits: cycles in HOLD with id_shouldStall=1) and perf_dropped (16 bits: responses discarded via redirect).
- All counters reset to 0, saturate at max, and count only when cpu_en=1.
- When not defined, these ports and their logic are absent; other behaviour is identical.

Decomposition:
- Shared package pipeline_pkg:
  - fetch state enum (FETCH, WAIT, HOLD, DROP).
  - NOP_INSTR = 32'h0.
  - XLEN = 32.
  - PC_ALIGN_MASK = 32'hFFFF_FFFC.
- Natural sub-module: if_perf_counters (saturating counters), instantiated only under IF_PERF_CNT_EN.

Test Plan:
- Reset with RESET_PC=0x100, zero-latency memory returning 0xA0+addr, no stalls:
  - imem_addr sequence 0x100, 0x104, 0x108.
  - if_pc_4 = 0x104, 0x108, 0x10C with if_valid pulses.
- HOLD with instr 0x1234_5678, id_shouldStall=1 for 4 cycles:
  - outputs stable for all 4 cycles; no new request.
  - after stall release, next imem_addr = buf_pc+4.
- Request to 0x200 accepted, redirect to 0x403 asserted during WAIT, response arrives 3 cycles later:
  - response discarded; next imem_addr = 0x400; if_valid never shows the 0x200 data.
- Redirect to 0x80 in the same cycle as imem_rsp_valid in WAIT:
  - data dropped; FETCH issues 0x80 next cycle.
- cpu_en=0 while in WAIT, response arrives:
  - instruction captured into HOLD; if_valid=1, but not consumed until cpu_en=1.
- rst_n asserted low mid-WAIT:
  - outputs are 0 immediately (asynchronously).
  - after release, the first imem_addr is RESET_PC; the stale response pulse is ignored.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM states, word size and fetch constants.
package pipeline_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR     = 32'h0;
    localparam logic [XLEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } fetch_state_e;
endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
interface if_fetch_stage_if;
    import pipeline_pkg::*;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid, imem_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data
    );
    modport slave (
        input  imem_req_valid, imem_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data
    );
endinterface

// File: rtl/if_fetch_stage_perf.sv
// Saturating fetch counters; only built when IF_PERF_CNT_EN is defined.
module if_perf_counters (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_en,
    input  logic        inc_fetched,
    input  logic        inc_stall,
    input  logic        inc_dropped,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
    output logic [15:0] perf_dropped
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
            perf_dropped <= '0;
        end else if (cpu_en) begin
            if (inc_fetched && perf_fetched != '1) perf_fetched <= perf_fetched + 32'd1;
            if (inc_stall   && perf_stall   != '1) perf_stall   <= perf_stall   + 32'd1;
            if (inc_dropped && perf_dropped != '1) perf_dropped <= perf_dropped + 16'd1;
        end
    end
endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage: owns the PC, single-outstanding imem requests, one-entry buffer to IF/ID.
// Optional perf counters under IF_PERF_CNT_EN.
module if_fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cpu_en,
    input  logic            id_shouldStall,
    input  logic            ex_shouldJumpOrBranch,
    input  logic [XLEN-1:0] ex_target,
    if_fetch_stage_if.master imem,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc_4,
    output logic [XLEN-1:0] if_instruction
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_stall,
    output logic [15:0]     perf_dropped
`endif
);
    fetch_state_e    state, state_nxt;
    logic [XLEN-1:0] pc, req_pc, buf_instr, buf_pc4;
    logic            redirect, hs, latch_req, capture, consume, dropped;

    assign redirect = cpu_en & ex_shouldJumpOrBranch;
    // Gated by rst_n so no request is seen while reset is held.
    assign imem.imem_req_valid = rst_n & cpu_en & (state == FETCH);
    assign imem.imem_addr      = pc;
    assign hs = imem.imem_req_valid & imem.imem_req_ready;

    always_comb begin
        state_nxt = state;
        latch_req = 1'b0;
        capture   = 1'b0;
        consume   = 1'b0;
        dropped   = 1'b0;
        case (state)
            FETCH: if (hs) begin
                latch_req = 1'b1;
                state_nxt = redirect ? DROP : WAIT;
            end
            WAIT: begin
                if (imem.imem_rsp_valid) begin
                    capture   = !redirect;
                    dropped   = redirect;
                    state_nxt = redirect ? FETCH : HOLD;
                end else if (redirect) begin
                    state_nxt = DROP;
                end
            end
            HOLD: begin
                if (redirect) begin
                    state_nxt = FETCH;
                end else if (cpu_en && !id_shouldStall) begin
                    consume   = 1'b1;
                    state_nxt = FETCH;
                end
            end
            DROP: if (imem.imem_rsp_valid) begin
                dropped   = 1'b1;
                state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            req_pc    <= '0;
            buf_instr <= NOP_INSTR;
            buf_pc4   <= '0;
        end else begin
            state <= state_nxt;
            if (redirect)     pc <= ex_target & PC_ALIGN_MASK;
            else if (consume) pc <= buf_pc4;
            if (latch_req) req_pc <= pc;
            if (capture) begin
                buf_instr <= imem.imem_rsp_data;
                buf_pc4   <= req_pc + 32'd4;
            end
        end
    end

    assign if_valid       = (state == HOLD);
    assign if_instruction = if_valid ? buf_instr : NOP_INSTR;
    assign if_pc_4        = if_valid ? buf_pc4 : '0;

`ifdef IF_PERF_CNT_EN
    if_perf_counters u_perf (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_en       (cpu_en),
        .inc_fetched  (consume),
        .inc_stall    ((state == HOLD) && id_shouldStall),
        .inc_dropped  (dropped),
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall),
        .perf_dropped (perf_dropped)
    );
`endif
endmodule
